// File: rtl/pow2_poly_eval.sv
// pow2_poly_eval: 4-stage order-2 polynomial evaluator for the 2^frac(x) fraction path.
// y = c0 + c1*dx + c2*dx^2 with coefficients returned by an external segment LUT.
module pow2_poly_eval #(
    parameter int LSB_W    = 10,
    parameter int EXP_W    = 9,
    parameter int OUT_FRAC = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [11:0]             x_msb_in,
    input  logic [LSB_W-1:0]        x_lsb_in,
    input  logic [EXP_W-1:0]        exp_in,
    output logic [11:0]             lut_x_msb,
    input  logic signed [28:0]      lut_c0,
    input  logic signed [24:0]      lut_c1,
    input  logic signed [16:0]      lut_c2,
    input  logic signed [13:0]      lut_a,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_FRAC:0]       y_out,
    output logic [EXP_W-1:0]        exp_out
);

    localparam int RND_SH = 26 - OUT_FRAC;
    localparam logic signed [34:0] RND_K = 35'sd1 <<< (25 - OUT_FRAC);

    logic                    en_s;
    logic                    v1_q, v2_q, v3_q, ov_q;
    logic [11:0]             x_msb_q;
    logic [LSB_W-1:0]        x_lsb_q;
    logic [EXP_W-1:0]        exp1_q, exp2_q, exp3_q, expo_q;
    logic signed [28:0]      c0_2_q, c0_3_q;
    logic signed [24:0]      c1_2_q;
    logic signed [16:0]      c2_2_q, c2_3_q;
    logic signed [23:0]      dx_q, dx_d, x_ext_s, a_ext_s;
    logic signed [48:0]      p1_q, p1_d, c1e_s, dxe49_s;
    logic [47:0]             sq_q, sq_d, dxe48_s;
    logic signed [64:0]      c2e_s, sqe_s, p2_s;
    logic signed [33:0]      c0e_s, sum_s;
    logic signed [34:0]      rnd_s, yw_s;
    logic [OUT_FRAC:0]       y_q, y_d;

    assign en_s      = ~ov_q | out_ready;
    assign in_ready  = en_s;
    assign lut_x_msb = x_msb_q;
    assign out_valid = ov_q;
    assign y_out     = y_q;
    assign exp_out   = expo_q;

    // dx is the offset of X from the segment midpoint, both in units of 2^-20
    assign x_ext_s = {{(12 - LSB_W){1'b0}}, x_msb_q, x_lsb_q};
    assign a_ext_s = {{10{lut_a[13]}}, lut_a} <<< (LSB_W - 1);
    assign dx_d    = x_ext_s - a_ext_s;

    assign c1e_s   = {{24{c1_2_q[24]}}, c1_2_q};
    assign dxe49_s = {{25{dx_q[23]}}, dx_q};
    assign p1_d    = c1e_s * dxe49_s;
    assign dxe48_s = {{24{dx_q[23]}}, dx_q};
    assign sq_d    = dxe48_s * dxe48_s;

    assign c2e_s = {{48{c2_3_q[16]}}, c2_3_q};
    assign sqe_s = {17'd0, sq_q};
    assign p2_s  = c2e_s * sqe_s;
    assign c0e_s = {{5{c0_3_q[28]}}, c0_3_q};
    assign sum_s = c0e_s + 34'(p1_q >>> 17) + 34'(p2_s >>> 30);
    assign rnd_s = {sum_s[33], sum_s} + RND_K;
    assign yw_s  = rnd_s >>> RND_SH;

    // Final stage: clamp negative sums to zero and saturate overflow to all ones
    always_comb begin
        y_d = {(OUT_FRAC + 1){1'b0}};
        if (sum_s[33]) begin
            y_d = {(OUT_FRAC + 1){1'b0}};
        end else if (|yw_s[34:OUT_FRAC+1]) begin
            y_d = {(OUT_FRAC + 1){1'b1}};
        end else begin
            y_d = yw_s[OUT_FRAC:0];
        end
    end

    // Stage valids: flush kills every stage even while the pipe is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (en_s) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            ov_q <= v3_q;
        end
    end

    // Datapath registers, all stages advance together on the global enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_msb_q <= 12'd0;
            x_lsb_q <= {LSB_W{1'b0}};
            exp1_q  <= {EXP_W{1'b0}};
            c0_2_q  <= 29'sd0;
            c1_2_q  <= 25'sd0;
            c2_2_q  <= 17'sd0;
            dx_q    <= 24'sd0;
            exp2_q  <= {EXP_W{1'b0}};
            p1_q    <= 49'sd0;
            sq_q    <= 48'd0;
            c0_3_q  <= 29'sd0;
            c2_3_q  <= 17'sd0;
            exp3_q  <= {EXP_W{1'b0}};
            y_q     <= {(OUT_FRAC + 1){1'b0}};
            expo_q  <= {EXP_W{1'b0}};
        end else if (en_s) begin
            x_msb_q <= x_msb_in;
            x_lsb_q <= x_lsb_in;
            exp1_q  <= exp_in;
            c0_2_q  <= lut_c0;
            c1_2_q  <= lut_c1;
            c2_2_q  <= lut_c2;
            dx_q    <= dx_d;
            exp2_q  <= exp1_q;
            p1_q    <= p1_d;
            sq_q    <= sq_d;
            c0_3_q  <= c0_2_q;
            c2_3_q  <= c2_2_q;
            exp3_q  <= exp2_q;
            y_q     <= y_d;
            expo_q  <= exp3_q;
        end
    end

endmodule

// File: tb/tb_pow2_poly_eval.sv
// Self-checking bench for pow2_poly_eval: behavioural LUT + arithmetic model and scoreboard,
// plus literal checks for known 2^x values, saturation, stalls, flush and reset.
module tb_pow2_poly_eval;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [11:0] x_msb_in, lut_x_msb;
    logic [9:0]  x_lsb_in;
    logic [8:0]  exp_in, exp_out;
    logic [28:0] lut_c0;
    logic [24:0] lut_c1;
    logic [16:0] lut_c2;
    logic [13:0] lut_a;
    logic [23:0] y_out;

    int lut_mode = 0;
    int n_vec = 0, n_err = 0, n_out = 0, n_stall = 0, cyc = 0, stall_end = 0;
    bit rand_ready = 1'b0, stall_force = 1'b0;
    longint q_y[$];
    int     q_e[$];
    bit     hold_v = 1'b0;
    longint hold_y, ey;
    int     hold_e, ee;

    pow2_poly_eval dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .x_msb_in(x_msb_in), .x_lsb_in(x_lsb_in), .exp_in(exp_in), .lut_x_msb(lut_x_msb),
        .lut_c0(lut_c0), .lut_c1(lut_c1), .lut_c2(lut_c2), .lut_a(lut_a),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .exp_out(exp_out)
    );

    always #5 clk = ~clk;

    // Coefficient source: 0 = Taylor table of 2^x at segment midpoints, 1/2 = forced c0, 3 = hashed
    function automatic void lut_vals(input int x, input int mode,
                                     output longint c0, output longint c1,
                                     output longint c2, output longint a);
        int idx;
        real m, v;
        logic [31:0] h0, h1, h2;
        logic signed [28:0] t0;
        logic signed [24:0] t1;
        logic signed [16:0] t2;
        logic signed [13:0] ta;
        idx = (x > 1031) ? 1031 : x;
        a   = 2 * idx + 1;
        m   = real'(a) / 2048.0;
        v   = 2.0 ** m;
        c0  = longint'($rtoi(v * 67108864.0 + 0.5));
        c1  = longint'($rtoi(v * 0.6931471805599453 * 8388608.0 + 0.5));
        c2  = longint'($rtoi(v * 0.2402265069591007 * 65536.0 + 0.5));
        if (mode == 1) c0 = 268435455;
        if (mode == 2) c0 = -268435456;
        if (mode == 3) begin
            h0 = 32'(x) * 32'h9E3779B1 + 32'h00012345;
            h1 = (h0 ^ 32'h0000A5A5) * 32'h85EBCA6B;
            h2 = (h1 + 32'd77) * 32'hC2B2AE35;
            t0 = h0[31:3];
            t1 = h1[31:7];
            t2 = h1[16:0];
            ta = h2[31:18];
            c0 = t0; c1 = t1; c2 = t2; a = ta;
        end
    endfunction

    always_comb begin
        longint c0, c1, c2, a;
        lut_vals(int'(lut_x_msb), lut_mode, c0, c1, c2, a);
        lut_c0 = c0[28:0];
        lut_c1 = c1[24:0];
        lut_c2 = c2[16:0];
        lut_a  = a[13:0];
    end

    // Reference: y = c0 + c1*dx + c2*dx^2 in fixed point, rounded to Q1.23 and clamped
    function automatic longint model_y(input int xm, input int xl, input int mode);
        longint c0, c1, c2, a, dx, sum, y;
        lut_vals(xm, mode, c0, c1, c2, a);
        dx  = longint'(xm) * 1024 + longint'(xl) - a * 512;
        sum = c0 + ((c1 * dx) >>> 17) + ((c2 * (dx * dx)) >>> 30);
        if (sum < 0) return 0;
        y = (sum + 4) >>> 3;
        return (y > 64'sd16777215) ? 64'sd16777215 : y;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint req, input longint tol);
        n_vec++;
        if (act > req + tol || act < req - tol) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, req, tol);
        end
    endtask

    // Scoreboard: push accepted beats, pop on output handshake, check held outputs stay stable
    always @(negedge clk) begin
        if (rst) begin
            q_y.delete(); q_e.delete(); hold_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (hold_v) begin
                    check("hold_y", longint'(y_out), hold_y);
                    check("hold_exp", longint'(exp_out), longint'(hold_e));
                end
                if (out_ready) begin
                    if (q_y.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_out: got y=0x%0h, expected no output", y_out);
                    end else begin
                        ey = q_y.pop_front(); ee = q_e.pop_front(); n_out++;
                        check("y_out", longint'(y_out), ey);
                        check("exp_out", longint'(exp_out), longint'(ee));
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1; hold_y = longint'(y_out); hold_e = int'(exp_out);
                end
            end else begin
                hold_v = 1'b0;
            end
            if (flush) begin
                q_y.delete(); q_e.delete(); hold_v = 1'b0;
            end
            if (in_valid && in_ready && !flush) begin
                q_y.push_back(model_y(int'(x_msb_in), int'(x_lsb_in), lut_mode));
                q_e.push_back(int'(exp_in));
            end
            if (in_valid && !in_ready) n_stall++;
        end
    end

    // Downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (stall_force || cyc < stall_end) out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int xm, input int xl, input int e, input bit rf);
        bit acc;
        int g;
        x_msb_in = 12'(xm); x_lsb_in = 10'(xl); exp_in = 9'(e);
        in_valid = 1'b1; acc = 1'b0; g = 0;
        while (!acc && g < 200) begin
            flush = rf && ($urandom_range(0, 15) == 0);
            @(negedge clk); acc = in_ready && !flush;
            @(posedge clk); #1; g++;
        end
        flush = 1'b0; in_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: beat x=%0d not accepted in %0d cycles", xm, g);
        end
    endtask

    task automatic wait_out();
        int g = 0;
        while (!out_valid && g < 50) begin step(1); g++; end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL wait_out: out_valid 0 after %0d cycles, expected 1", g);
        end
    endtask

    task automatic drain();
        int g = 0;
        rand_ready = 1'b0; stall_force = 1'b0;
        while ((q_y.size() != 0 || out_valid) && g < 100) begin step(1); g++; end
        if (g >= 100) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", q_y.size());
        end
    endtask

    initial begin
        int o0, s0, cnt;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        x_msb_in = 12'd0; x_lsb_in = 10'd0; exp_in = 9'd0;

        check_near("model_x0", model_y(0, 0, 0), 64'h800000, 2);
        check_near("model_sqrt2", model_y(512, 0, 0), 64'hB504F3, 2);
        check("model_sat", model_y(100, 5, 1), 64'hFFFFFF);
        check("model_neg", model_y(100, 5, 2), 64'h0);

        step(3);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y", longint'(y_out), 0);
        check("rst_exp", longint'(exp_out), 0);
        check("rst_lut_x", longint'(lut_x_msb), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        step(2);

        // Latency: visible exactly three edges after the accepting edge
        send(0, 0, 3, 1'b0);
        check("lat_e0", longint'(out_valid), 0);
        step(1); check("lat_e1", longint'(out_valid), 0);
        step(1); check("lat_e2", longint'(out_valid), 0);
        step(1); check("lat_e3", longint'(out_valid), 1);
        check_near("y_x0", longint'(y_out), 64'h800000, 2);
        check("exp_x0", longint'(exp_out), 3);
        drain();

        send(512, 0, 31, 1'b0); wait_out();
        check_near("y_sqrt2", longint'(y_out), 64'hB504F3, 2);
        drain();
        send(1023, 1023, 5, 1'b0); wait_out();
        check("y_top_hi", longint'(y_out) >>> 12, 64'hFFF);
        drain();

        // 16 back-to-back beats give 16 consecutive results
        fork
            for (int i = 0; i < 16; i++)
                send($urandom_range(0, 1031), $urandom_range(0, 1023), $urandom_range(0, 511), 1'b0);
            begin
                wait_out(); cnt = 0;
                while (out_valid && cnt < 40) begin cnt++; step(1); end
                check("stream_run", cnt, 16);
            end
        join
        drain();

        // Downstream stall while 8 beats are offered
        o0 = n_out; s0 = n_stall;
        stall_end = cyc + 7;
        for (int i = 0; i < 8; i++)
            send($urandom_range(0, 1031), $urandom_range(0, 1023), i, 1'b0);
        drain();
        check("stall_seen", longint'(n_stall > s0), 1);
        check("stall_count", n_out - o0, 8);

        lut_mode = 1; send(100, 5, 7, 1'b0); wait_out();
        check("y_c0_max", longint'(y_out), 64'hFFFFFF);
        drain();
        lut_mode = 2; send(100, 5, 7, 1'b0); wait_out();
        check("y_c0_neg", longint'(y_out), 0);
        drain();
        lut_mode = 0;

        // Asynchronous reset with the pipe full and stalled
        stall_force = 1'b1;
        for (int i = 0; i < 3; i++) send(200 + i, 0, i, 1'b0);
        step(3);
        check("pre_rst_valid", longint'(out_valid), 1);
        #2 rst = 1'b1;
        #1 check("rst_async_valid", longint'(out_valid), 0);
        check("rst_async_y", longint'(y_out), 0);
        stall_force = 1'b0;
        step(2); rst = 1'b0;
        step(1);

        // Flush with three beats in flight and a fourth offered on the flush cycle
        for (int i = 0; i < 3; i++) send(300 + i, 0, i, 1'b0);
        flush = 1'b1; in_valid = 1'b1; x_msb_in = 12'd400;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("flush_quiet", longint'(out_valid), 0);
            step(1);
        end

        // Randomized traffic: hashed coefficients, then the real table, with random flush/backpressure
        lut_mode = 3; rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 4095), $urandom_range(0, 1023), $urandom_range(0, 511), 1'b1);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
        end
        drain();
        lut_mode = 0; rand_ready = 1'b1;
        for (int i = 0; i < 200; i++)
            send($urandom_range(0, 4095), $urandom_range(0, 1023), $urandom_range(0, 511), 1'b1);
        drain();
        check("scoreboard_empty", q_y.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
